// File: rtl/data_memory_pkg.sv
// Shared defaults and FSM state type for the data memory controller.
package data_memory_pkg;

    localparam int DEFAULT_DATA_W = 16;
    localparam int DEFAULT_ADDR_W = 11;
    localparam int DEFAULT_DEPTH  = 2048;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

endpackage

// File: rtl/data_memory_ctrl_if.sv
// Request/response bundle between a memory client (master) and the controller (slave).
interface data_memory_ctrl_if
    import data_memory_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ADDR_W = DEFAULT_ADDR_W
);

    logic              read_enable;
    logic [ADDR_W-1:0] read_addr;
    logic              write_enable;
    logic [ADDR_W-1:0] write_addr;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] read_data;
    logic              read_valid;
    logic              busy;
    logic              addr_err;

    modport master (
        output read_enable, read_addr, write_enable, write_addr, write_data,
        input  read_data, read_valid, busy, addr_err
    );

    modport slave (
        input  read_enable, read_addr, write_enable, write_addr, write_data,
        output read_data, read_valid, busy, addr_err
    );

endinterface

// File: rtl/data_memory_clear_fsm.sv
// Clear-sweep sequencer: walks every word once after reset, then parks in READY.
module data_memory_clear_fsm
    import data_memory_pkg::*;
#(
    parameter  int DEPTH = DEFAULT_DEPTH,
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    output logic             o_busy,
    output logic             o_sweep_we,
    output logic [IDX_W-1:0] o_sweep_addr
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    state_t           r_state;
    logic [IDX_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= CLEAR;
            r_count <= '0;
        end else if (r_state == CLEAR) begin
            // The last word is written on the same edge that leaves CLEAR.
            if (r_count == LAST_IDX) begin
                r_state <= READY;
                r_count <= '0;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign o_busy       = (r_state == CLEAR);
    assign o_sweep_we   = (r_state == CLEAR);
    assign o_sweep_addr = r_count;

endmodule

// File: rtl/data_memory_ctrl.sv
// Single-port-write / single-port-read data memory with power-up clear sweep,
// range checking and write-first forwarding.
module data_memory_ctrl
    import data_memory_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DEPTH  = DEFAULT_DEPTH
) (
    input  logic                clk,
    input  logic                rst,
    data_memory_ctrl_if.slave   bus
);

    localparam int                IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    logic             w_busy;
    logic             w_sweep_we;
    logic [IDX_W-1:0] w_sweep_addr;

    data_memory_clear_fsm #(
        .DEPTH (DEPTH)
    ) u_clear_fsm (
        .clk          (clk),
        .rst          (rst),
        .o_busy       (w_busy),
        .o_sweep_we   (w_sweep_we),
        .o_sweep_addr (w_sweep_addr)
    );

    logic             w_rd_req;
    logic             w_wr_req;
    logic             w_rd_ok;
    logic             w_wr_ok;
    logic             w_fwd;
    logic [IDX_W-1:0] w_rd_idx;
    logic [IDX_W-1:0] w_wr_idx;

    assign w_rd_req = bus.read_enable  & ~w_busy;
    assign w_wr_req = bus.write_enable & ~w_busy;
    // Zero-extended compare so addresses beyond DEPTH never alias onto real words.
    assign w_rd_ok  = ({1'b0, bus.read_addr}  < DEPTH_EXT);
    assign w_wr_ok  = ({1'b0, bus.write_addr} < DEPTH_EXT);
    assign w_rd_idx = bus.read_addr[IDX_W-1:0];
    assign w_wr_idx = bus.write_addr[IDX_W-1:0];
    assign w_fwd    = w_rd_req & w_rd_ok & w_wr_req & w_wr_ok &
                      (bus.read_addr == bus.write_addr);

    logic             w_mem_we;
    logic [IDX_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_wdata;

    assign w_mem_we    = rst & (w_sweep_we | (w_wr_req & w_wr_ok));
    assign w_mem_addr  = w_sweep_we ? w_sweep_addr : w_wr_idx;
    assign w_mem_wdata = w_sweep_we ? '0 : bus.write_data;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_mem_q;
    logic [DATA_W-1:0] r_fwd_data;

    // Array and its read register carry no reset so they map onto block RAM.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
        if (w_rd_req & w_rd_ok) begin
            r_mem_q <= r_mem[w_rd_idx];
        end
        r_fwd_data <= bus.write_data;
    end

    logic r_read_valid;
    logic r_sel_mem;
    logic r_sel_fwd;
    logic r_addr_err;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_read_valid <= 1'b0;
            r_sel_mem    <= 1'b0;
            r_sel_fwd    <= 1'b0;
            r_addr_err   <= 1'b0;
        end else begin
            r_read_valid <= w_rd_req;
            r_sel_mem    <= w_rd_req & w_rd_ok & ~w_fwd;
            r_sel_fwd    <= w_fwd;
            r_addr_err   <= (w_rd_req & ~w_rd_ok) | (w_wr_req & ~w_wr_ok);
        end
    end

    assign bus.read_data  = r_sel_fwd ? r_fwd_data :
                            r_sel_mem ? r_mem_q    : '0;
    assign bus.read_valid = r_read_valid;
    assign bus.addr_err   = r_addr_err;
    assign bus.busy       = w_busy;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench: a full-depth instance and a DEPTH=1000 instance driven from a vector table
// plus hand sequences for the sweep, mid-sweep reset and busy-time requests.
module tb_data_memory_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    data_memory_ctrl_if #(.DATA_W(16), .ADDR_W(11)) bus0 ();
    data_memory_ctrl_if #(.DATA_W(16), .ADDR_W(11)) bus1 ();

    data_memory_ctrl #(.DATA_W(16), .ADDR_W(11), .DEPTH(2048)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    data_memory_ctrl #(.DATA_W(16), .ADDR_W(11), .DEPTH(1000)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    typedef struct {
        logic        sel;
        logic        re;
        logic [10:0] ra;
        logic        we;
        logic [10:0] wa;
        logic [15:0] wd;
        logic [15:0] exp_rd;
        logic        exp_v;
        logic        exp_e;
    } vec_t;

    vec_t vecs[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic idle0();
        bus0.read_enable  = 1'b0;
        bus0.read_addr    = '0;
        bus0.write_enable = 1'b0;
        bus0.write_addr   = '0;
        bus0.write_data   = '0;
    endtask

    task automatic idle1();
        bus1.read_enable  = 1'b0;
        bus1.read_addr    = '0;
        bus1.write_enable = 1'b0;
        bus1.write_addr   = '0;
        bus1.write_data   = '0;
    endtask

    task automatic add(input logic sel, input logic re, input logic [10:0] ra,
                       input logic we, input logic [10:0] wa, input logic [15:0] wd,
                       input logic [15:0] exp_rd, input logic exp_v, input logic exp_e);
        vec_t v;
        v.sel = sel; v.re = re; v.ra = ra; v.we = we; v.wa = wa; v.wd = wd;
        v.exp_rd = exp_rd; v.exp_v = exp_v; v.exp_e = exp_e;
        vecs.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        idle0();
        idle1();
        if (v.sel == 1'b0) begin
            bus0.read_enable = v.re; bus0.read_addr = v.ra;
            bus0.write_enable = v.we; bus0.write_addr = v.wa; bus0.write_data = v.wd;
        end else begin
            bus1.read_enable = v.re; bus1.read_addr = v.ra;
            bus1.write_enable = v.we; bus1.write_addr = v.wa; bus1.write_data = v.wd;
        end
    endtask

    // Called at a falling edge; returns per-instance busy cycle counts and
    // any read_valid/addr_err pulses seen while either instance was sweeping.
    task automatic sweep_wait(output int c0, output int c1, output int pulses);
        c0 = 0; c1 = 0; pulses = 0;
        for (int c = 0; c < 5000 && (bus0.busy || bus1.busy); c++) begin
            if (bus0.busy) c0++; else idle0();
            if (bus1.busy) c1++; else idle1();
            @(negedge clk);
            if (bus0.read_valid || bus0.addr_err || bus1.read_valid || bus1.addr_err)
                pulses++;
        end
        idle0();
        idle1();
    endtask

    initial begin
        int c0, c1, pulses;
        vec_t v;

        idle0();
        idle1();
        bus0.read_enable = 1'b1;
        bus0.write_enable = 1'b1;
        bus0.write_data = 16'hDEAD;
        repeat (3) @(negedge clk);
        chk("reset_rdata", bus0.read_data, 16'h0);
        chk("reset_rvalid", bus0.read_valid, 1'b0);
        chk("reset_err", bus0.addr_err, 1'b0);
        chk("reset_busy0", bus0.busy, 1'b1);
        chk("reset_busy1", bus1.busy, 1'b1);

        // Release reset with requests held for the whole sweep.
        rst = 1'b1;
        bus0.read_enable = 1'b1; bus0.read_addr = 11'd3;
        bus0.write_enable = 1'b1; bus0.write_addr = 11'd3; bus0.write_data = 16'hAAAA;
        bus1.read_enable = 1'b1; bus1.read_addr = 11'd3;
        bus1.write_enable = 1'b1; bus1.write_addr = 11'd1500; bus1.write_data = 16'hAAAA;
        sweep_wait(c0, c1, pulses);
        $display("sweep: busy0=%0d busy1=%0d pulses=%0d", c0, c1, pulses);
        chk("busy_cycles0", c0, 2048);
        chk("busy_cycles1", c1, 1000);
        chk("sweep_pulses", pulses, 0);
        chk("ready_busy0", bus0.busy, 1'b0);

        add(0, 1, 11'd3,    0, 11'd0,    16'h0000, 16'h0000, 1, 0);
        add(0, 1, 11'd0,    0, 11'd0,    16'h0000, 16'h0000, 1, 0);
        add(0, 1, 11'd1023, 0, 11'd0,    16'h0000, 16'h0000, 1, 0);
        add(0, 1, 11'd2047, 0, 11'd0,    16'h0000, 16'h0000, 1, 0);
        add(0, 0, 11'd0,    1, 11'd5,    16'hBEEF, 16'h0000, 0, 0);
        add(0, 1, 11'd5,    0, 11'd0,    16'h0000, 16'hBEEF, 1, 0);
        add(0, 0, 11'd0,    0, 11'd0,    16'h0000, 16'h0000, 0, 0);
        add(0, 1, 11'd7,    1, 11'd7,    16'h1234, 16'h1234, 1, 0);
        add(0, 1, 11'd7,    0, 11'd0,    16'h0000, 16'h1234, 1, 0);
        add(0, 1, 11'd2047, 1, 11'd2047, 16'h5A5A, 16'h5A5A, 1, 0);
        add(0, 1, 11'd5,    1, 11'd9,    16'h00FF, 16'hBEEF, 1, 0);
        add(0, 1, 11'd9,    0, 11'd0,    16'h0000, 16'h00FF, 1, 0);
        add(0, 1, 11'd8,    0, 11'd0,    16'h0000, 16'h0000, 1, 0);
        add(0, 1, 11'd5,    1, 11'd7,    16'h9999, 16'hBEEF, 1, 0);
        add(0, 1, 11'd7,    0, 11'd0,    16'h0000, 16'h9999, 1, 0);
        add(1, 1, 11'd3,    0, 11'd0,    16'h0000, 16'h0000, 1, 0);
        add(1, 1, 11'd1000, 1, 11'd1500, 16'hFFFF, 16'h0000, 1, 1);
        add(1, 0, 11'd0,    0, 11'd0,    16'h0000, 16'h0000, 0, 0);
        add(1, 1, 11'd476,  0, 11'd0,    16'h0000, 16'h0000, 1, 0);
        add(1, 1, 11'd999,  1, 11'd999,  16'h0F0F, 16'h0F0F, 1, 0);
        add(1, 0, 11'd0,    1, 11'd1000, 16'h2222, 16'h0000, 0, 1);
        add(1, 1, 11'd999,  0, 11'd0,    16'h0000, 16'h0F0F, 1, 0);
        add(1, 1, 11'd2047, 0, 11'd0,    16'h0000, 16'h0000, 1, 1);
        add(1, 1, 11'd998,  1, 11'd1023, 16'h3333, 16'h0000, 1, 1);
        add(1, 1, 11'd1000, 1, 11'd1000, 16'h7777, 16'h0000, 1, 1);
        add(1, 1, 11'd488,  0, 11'd0,    16'h0000, 16'h0000, 1, 0);

        foreach (vecs[i]) begin
            v = vecs[i];
            drive(v);
            @(negedge clk);
            if (v.sel == 1'b0) begin
                $display("vec %0d dut0: rd=0x%0h v=%0b e=%0b", i, bus0.read_data, bus0.read_valid, bus0.addr_err);
                chk($sformatf("v%0d_rdata", i), bus0.read_data, v.exp_rd);
                chk($sformatf("v%0d_rvalid", i), bus0.read_valid, v.exp_v);
                chk($sformatf("v%0d_err", i), bus0.addr_err, v.exp_e);
            end else begin
                $display("vec %0d dut1: rd=0x%0h v=%0b e=%0b", i, bus1.read_data, bus1.read_valid, bus1.addr_err);
                chk($sformatf("v%0d_rdata", i), bus1.read_data, v.exp_rd);
                chk($sformatf("v%0d_rvalid", i), bus1.read_valid, v.exp_v);
                chk($sformatf("v%0d_err", i), bus1.addr_err, v.exp_e);
            end
        end
        idle0();
        idle1();

        // Store a value, then reset mid-operation and again at sweep count 300.
        bus0.write_enable = 1'b1; bus0.write_addr = 11'd100; bus0.write_data = 16'h4444;
        @(negedge clk);
        idle0();
        bus0.read_enable = 1'b1; bus0.read_addr = 11'd100;
        @(negedge clk);
        chk("pre_reset_rd", bus0.read_data, 16'h4444);
        rst = 1'b0;
        @(negedge clk);
        chk("midop_reset_rvalid", bus0.read_valid, 1'b0);
        chk("midop_reset_rdata", bus0.read_data, 16'h0);
        chk("midop_reset_busy", bus0.busy, 1'b1);
        idle0();
        rst = 1'b1;
        repeat (300) @(negedge clk);
        chk("sweep300_busy", bus0.busy, 1'b1);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        sweep_wait(c0, c1, pulses);
        $display("restart sweep: busy0=%0d busy1=%0d pulses=%0d", c0, c1, pulses);
        chk("restart_busy_cycles0", c0, 2048);
        chk("restart_pulses", pulses, 0);
        bus0.read_enable = 1'b1; bus0.read_addr = 11'd100;
        @(negedge clk);
        chk("post_reset_rd", bus0.read_data, 16'h0);
        chk("post_reset_rvalid", bus0.read_valid, 1'b1);
        idle0();
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
